// File: rtl/vram_write_sched.sv
// VRAM write scheduler: merges a buffered CPU write stream and a whole-VRAM
// fill engine onto one write port, issuing writes only inside the write window.
module vram_write_sched #(
  parameter int C_AW         = 10,
  parameter int C_DW         = 8,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic                            CK_i,
  input  logic                            AR_i,
  input  logic                            CK_EE_i,
  input  logic                            BLANK_i,
  input  logic                            WR_ANYTIME_i,
  input  logic [C_DW-1:0]                 CPU_WDs_i,
  input  logic [C_AW-1:0]                 CPU_WAs_i,
  input  logic                            CPU_WE_i,
  output logic                            CPU_RDY_o,
  output logic                            CPU_OVF_o,
  output logic [$clog2(C_FIFO_DEPTH):0]   FIFO_LEVELs_o,
  input  logic                            FILL_START_i,
  input  logic                            FILL_INC_i,
  input  logic [C_DW-1:0]                 FILL_DATs_i,
  output logic                            FILL_BUSY_o,
  output logic [C_DW-1:0]                 VRAM_WDs_o,
  output logic [C_AW-1:0]                 VRAM_WAs_o,
  output logic                            VRAM_WE_o
);

  localparam int PW = $clog2(C_FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = C_AW + C_DW;

  typedef enum logic {S_IDLE, S_RUN} fill_state_e;

  logic [EW-1:0]   fifo_mem_q [C_FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q;

  fill_state_e     state_q;
  logic [C_AW-1:0] fill_addr_q;
  logic [C_DW-1:0] fill_dat_q;
  logic            fill_inc_q;

  logic            we_q;
  logic [C_AW-1:0] wa_q;
  logic [C_DW-1:0] wd_q;
  logic            last_fill_q;

  logic            cpu_rdy;
  logic            push;
  logic            pop;
  logic            window;
  logic            cpu_req;
  logic            fill_req;
  logic            grant_cpu;
  logic            grant_fill;
  logic            fill_start;
  logic            fill_last;
  logic [EW-1:0]   fifo_head;

  assign cpu_rdy    = (level_q != LW'(C_FIFO_DEPTH));
  assign push       = CK_EE_i & CPU_WE_i & cpu_rdy;
  assign window     = BLANK_i | WR_ANYTIME_i;
  assign cpu_req    = (level_q != '0);
  assign fill_req   = (state_q == S_RUN);
  assign fill_start = (state_q == S_IDLE) & FILL_START_i;
  assign fill_last  = (fill_addr_q == '1);
  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign pop        = CK_EE_i & grant_cpu;

  // Round-robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    grant_cpu  = 1'b0;
    grant_fill = 1'b0;
    if (window) begin
      if (cpu_req && fill_req) begin
        grant_cpu  = last_fill_q;
        grant_fill = ~last_fill_q;
      end else begin
        grant_cpu  = cpu_req;
        grant_fill = fill_req;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // ---- CPU write FIFO ----
  always_ff @(posedge CK_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {CPU_WAs_i, CPU_WDs_i};
  end

  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (CK_EE_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (CPU_WE_i && !cpu_rdy) ovf_q <= 1'b1;
    end
  end

  // ---- Fill engine ----
  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      state_q <= S_IDLE;
    end else if (CK_EE_i) begin
      case (state_q)
        S_IDLE:  if (FILL_START_i) state_q <= S_RUN;
        S_RUN:   if (grant_fill && fill_last) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK_i) begin
    if (CK_EE_i) begin
      if (fill_start) begin
        fill_addr_q <= '0;
        fill_dat_q  <= FILL_DATs_i;
        fill_inc_q  <= FILL_INC_i;
      end else if (grant_fill) begin
        fill_addr_q <= fill_addr_q + C_AW'(1);
        if (fill_inc_q) fill_dat_q <= fill_dat_q + C_DW'(1);
      end
    end
  end

  // ---- VRAM write port registers ----
  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      we_q        <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
      last_fill_q <= 1'b1;
    end else if (CK_EE_i) begin
      we_q <= grant_cpu | grant_fill;
      if (grant_cpu) begin
        wa_q        <= fifo_head[EW-1:C_DW];
        wd_q        <= fifo_head[C_DW-1:0];
        last_fill_q <= 1'b0;
      end else if (grant_fill) begin
        wa_q        <= fill_addr_q;
        wd_q        <= fill_dat_q;
        last_fill_q <= 1'b1;
      end
    end
  end

  assign CPU_RDY_o     = cpu_rdy;
  assign CPU_OVF_o     = ovf_q;
  assign FIFO_LEVELs_o = level_q;
  assign FILL_BUSY_o   = (state_q == S_RUN);
  assign VRAM_WE_o     = we_q;
  assign VRAM_WAs_o    = wa_q;
  assign VRAM_WDs_o    = wd_q;

endmodule

// File: tb/tb_vram_write_sched.sv
// Directed bench for vram_write_sched with a scoreboard of expected VRAM writes.
module tb_vram_write_sched;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          CK_i = 1'b0;
  logic          AR_i = 1'b1;
  logic          CK_EE_i = 1'b0;
  logic          BLANK_i = 1'b0;
  logic          WR_ANYTIME_i = 1'b0;
  logic [DW-1:0] CPU_WDs_i = '0;
  logic [AW-1:0] CPU_WAs_i = '0;
  logic          CPU_WE_i = 1'b0;
  logic          CPU_RDY_o;
  logic          CPU_OVF_o;
  logic [2:0]    FIFO_LEVELs_o;
  logic          FILL_START_i = 1'b0;
  logic          FILL_INC_i = 1'b0;
  logic [DW-1:0] FILL_DATs_i = '0;
  logic          FILL_BUSY_o;
  logic [DW-1:0] VRAM_WDs_o;
  logic [AW-1:0] VRAM_WAs_o;
  logic          VRAM_WE_o;

  logic [AW+DW-1:0] sb[$];
  int n_chk = 0;
  int n_fail = 0;

  vram_write_sched #(.C_AW(AW), .C_DW(DW), .C_FIFO_DEPTH(DEPTH)) dut (
    .CK_i(CK_i), .AR_i(AR_i), .CK_EE_i(CK_EE_i), .BLANK_i(BLANK_i),
    .WR_ANYTIME_i(WR_ANYTIME_i), .CPU_WDs_i(CPU_WDs_i), .CPU_WAs_i(CPU_WAs_i),
    .CPU_WE_i(CPU_WE_i), .CPU_RDY_o(CPU_RDY_o), .CPU_OVF_o(CPU_OVF_o),
    .FIFO_LEVELs_o(FIFO_LEVELs_o), .FILL_START_i(FILL_START_i),
    .FILL_INC_i(FILL_INC_i), .FILL_DATs_i(FILL_DATs_i), .FILL_BUSY_o(FILL_BUSY_o),
    .VRAM_WDs_o(VRAM_WDs_o), .VRAM_WAs_o(VRAM_WAs_o), .VRAM_WE_o(VRAM_WE_o)
  );

  always #5 CK_i = ~CK_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One enable period: enabled edge followed by three disabled edges.
  task automatic step();
    CK_EE_i = 1'b1;
    @(posedge CK_i);
    #1;
    CK_EE_i = 1'b0;
    repeat (3) @(posedge CK_i);
    #1;
  endtask

  task automatic exp_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb.push_back({a, d});
  endtask

  task automatic step_expect(input logic we);
    logic [AW+DW-1:0] e;
    step();
    chk("vram_we", 32'(VRAM_WE_o), 32'(we));
    if (we) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("vram_wa", 32'(VRAM_WAs_o), 32'(e[AW+DW-1:DW]));
        chk("vram_wd", 32'(VRAM_WDs_o), 32'(e[DW-1:0]));
      end
    end
  endtask

  task automatic apply_reset();
    AR_i = 1'b1;
    repeat (2) @(posedge CK_i);
    #1;
    AR_i = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic [AW-1:0] na;
    logic [DW-1:0] dv;
    logic          b;

    // Reset values
    repeat (2) @(posedge CK_i);
    #1;
    chk("rst_we", 32'(VRAM_WE_o), 32'd0);
    chk("rst_wa", 32'(VRAM_WAs_o), 32'd0);
    chk("rst_wd", 32'(VRAM_WDs_o), 32'd0);
    chk("rst_level", 32'(FIFO_LEVELs_o), 32'd0);
    chk("rst_rdy", 32'(CPU_RDY_o), 32'd1);
    chk("rst_ovf", 32'(CPU_OVF_o), 32'd0);
    chk("rst_busy", 32'(FILL_BUSY_o), 32'd0);
    AR_i = 1'b0;

    // Single CPU write with the window forced open
    WR_ANYTIME_i = 1'b1;
    CPU_WE_i = 1'b1; CPU_WAs_i = 10'h123; CPU_WDs_i = 8'h5A;
    exp_push(10'h123, 8'h5A);
    step_expect(1'b0);
    CPU_WE_i = 1'b0;
    chk("t1_level_push", 32'(FIFO_LEVELs_o), 32'd1);
    step_expect(1'b1);
    chk("t1_level_pop", 32'(FIFO_LEVELs_o), 32'd0);
    step_expect(1'b0);

    // Overflow with window closed, then drain in FIFO order
    apply_reset();
    WR_ANYTIME_i = 1'b0; BLANK_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      CPU_WE_i = 1'b1;
      CPU_WAs_i = AW'(10'h010 + i);
      CPU_WDs_i = DW'(8'hA0 + i);
      if (i < 4) exp_push(AW'(10'h010 + i), DW'(8'hA0 + i));
      step_expect(1'b0);
    end
    CPU_WE_i = 1'b0;
    chk("t2_level_full", 32'(FIFO_LEVELs_o), 32'd4);
    chk("t2_rdy_full", 32'(CPU_RDY_o), 32'd0);
    chk("t2_ovf", 32'(CPU_OVF_o), 32'd1);
    BLANK_i = 1'b1;
    for (int i = 0; i < 4; i++) step_expect(1'b1);
    step_expect(1'b0);
    chk("t2_level_empty", 32'(FIFO_LEVELs_o), 32'd0);
    chk("t2_ovf_sticky", 32'(CPU_OVF_o), 32'd1);

    // Full incrementing fill
    apply_reset();
    WR_ANYTIME_i = 1'b1; BLANK_i = 1'b0;
    FILL_DATs_i = 8'hFE; FILL_INC_i = 1'b1; FILL_START_i = 1'b1;
    step_expect(1'b0);
    FILL_START_i = 1'b0;
    chk("t3_busy_start", 32'(FILL_BUSY_o), 32'd1);
    for (int i = 0; i < 1024; i++) begin
      dv = DW'(8'hFE + i);
      exp_push(AW'(i), dv);
    end
    for (int i = 0; i < 1024; i++) begin
      step_expect(1'b1);
      if (i == 1022) chk("t3_busy_before_last", 32'(FILL_BUSY_o), 32'd1);
      if (i == 1023) chk("t3_busy_at_last", 32'(FILL_BUSY_o), 32'd0);
    end
    step_expect(1'b0);

    // Contention, restart ignored mid-fill, reset mid-fill
    apply_reset();
    WR_ANYTIME_i = 1'b0; BLANK_i = 1'b0;
    FILL_DATs_i = 8'h40; FILL_INC_i = 1'b0; FILL_START_i = 1'b1;
    step_expect(1'b0);
    FILL_START_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      CPU_WE_i = 1'b1;
      CPU_WAs_i = AW'(10'h200 + i);
      CPU_WDs_i = DW'(8'h11 * (i + 1));
      step_expect(1'b0);
    end
    CPU_WE_i = 1'b0;
    chk("t4_level", 32'(FIFO_LEVELs_o), 32'd4);
    chk("t4_ovf", 32'(CPU_OVF_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      exp_push(AW'(10'h200 + i), DW'(8'h11 * (i + 1)));
      exp_push(AW'(i), 8'h40);
    end
    exp_push(10'd4, 8'h40);
    exp_push(10'd5, 8'h40);
    BLANK_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      FILL_START_i = (i == 6);
      FILL_DATs_i = (i == 6) ? 8'h77 : 8'h40;
      step_expect(1'b1);
    end
    FILL_START_i = 1'b0;
    CPU_WE_i = 1'b1; CPU_WAs_i = 10'h3FF; CPU_WDs_i = 8'h99;
    exp_push(10'd6, 8'h40);
    step_expect(1'b1);
    CPU_WE_i = 1'b0;
    chk("t5_level_pre_rst", 32'(FIFO_LEVELs_o), 32'd1);
    chk("t5_busy_pre_rst", 32'(FILL_BUSY_o), 32'd1);
    AR_i = 1'b1;
    #1;
    chk("t5_busy_in_rst", 32'(FILL_BUSY_o), 32'd0);
    chk("t5_we_in_rst", 32'(VRAM_WE_o), 32'd0);
    repeat (2) @(posedge CK_i);
    #1;
    AR_i = 1'b0;
    chk("t5_level_post_rst", 32'(FIFO_LEVELs_o), 32'd0);
    chk("t5_ovf_post_rst", 32'(CPU_OVF_o), 32'd0);
    chk("t5_rdy_post_rst", 32'(CPU_RDY_o), 32'd1);
    chk("t5_sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    step_expect(1'b0);

    // Fill with blanking toggling every 3 enables
    apply_reset();
    WR_ANYTIME_i = 1'b0; BLANK_i = 1'b0;
    FILL_DATs_i = 8'h00; FILL_INC_i = 1'b1; FILL_START_i = 1'b1;
    step_expect(1'b0);
    FILL_START_i = 1'b0;
    na = '0;
    for (int k = 0; k < 30; k++) begin
      b = (((k / 3) % 2) == 1);
      BLANK_i = b;
      if (b) begin
        exp_push(na, na[DW-1:0]);
        na = na + AW'(1);
      end
      step_expect(b);
    end
    chk("t6_busy", 32'(FILL_BUSY_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
